// File: rtl/uart_hex_tx.sv
// uart_hex_tx: sends one 5-character ASCII frame "$HH\r\n" over a UART line,
// where HH is the uppercase hex rendering of the latched value.
// Bit timing uses a 16x oversampling strobe (sample_tick); 16 ticks per bit,
// STOP_BIT_TICK ticks in the stop bit.
// Optional feature macro: UART_HEX_TX_PARITY_EN adds an even-parity bit per
// character between the data bits and the stop bit.
module uart_hex_tx #(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned STOP_BIT_TICK = 16
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] value,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0]  LAST_TICK = 4'd15;
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BIT_TICK - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_CHAR = 3'd4;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_HEX_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state, state_n;
    logic [3:0]           tick_cnt, tick_cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [2:0]           char_idx, char_idx_n;
    logic [DATA_BITS-1:0] value_q, value_q_n;
    logic                 tx_n;
    logic                 busy_n;
    logic                 frame_done_n;

    logic [7:0]           value8;
    logic [7:0]           cur_char8;
    logic [DATA_BITS-1:0] cur_data;
    logic [BIT_W-1:0]     bit_nxt;
    logic                 accept;
    logic                 tick_last;

    // Map a nibble to its uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    // Character currently being serialised, selected by the character index.
    always_comb begin
        value8 = 8'(value_q);
        case (char_idx)
            3'd0:    cur_char8 = CH_DOLLAR;
            3'd1:    cur_char8 = hex_ascii(value8[7:4]);
            3'd2:    cur_char8 = hex_ascii(value8[3:0]);
            3'd3:    cur_char8 = CH_CR;
            default: cur_char8 = CH_LF;
        endcase
        cur_data = DATA_BITS'(cur_char8);
    end

    // A request is taken only when fully idle, never on the frame_done cycle.
    assign accept    = send && (state == IDLE) && !busy && !frame_done;
    assign tick_last = (tick_cnt == LAST_TICK);
    assign bit_nxt   = bit_cnt + BIT_W'(1);

    // Next-state and next-output logic; counters only move on sample_tick.
    always_comb begin
        state_n      = state;
        tick_cnt_n   = tick_cnt;
        bit_cnt_n    = bit_cnt;
        char_idx_n   = char_idx;
        value_q_n    = value_q;
        tx_n         = tx;
        busy_n       = busy;
        frame_done_n = 1'b0;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (accept) begin
                    state_n    = START;
                    value_q_n  = value;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                    tick_cnt_n = 4'd0;
                    bit_cnt_n  = '0;
                    char_idx_n = 3'd0;
                end
            end

            START: begin
                if (sample_tick) begin
                    if (tick_last) begin
                        tick_cnt_n = 4'd0;
                        bit_cnt_n  = '0;
                        state_n    = DATA;
                        tx_n       = cur_data[0];
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end

            DATA: begin
                if (sample_tick) begin
                    if (tick_last) begin
                        tick_cnt_n = 4'd0;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_HEX_TX_PARITY_EN
                            state_n = PARITY;
                            tx_n    = ^cur_data;
`else
                            state_n = STOP;
                            tx_n    = 1'b1;
`endif
                        end else begin
                            bit_cnt_n = bit_nxt;
                            tx_n      = cur_data[bit_nxt];
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end

`ifdef UART_HEX_TX_PARITY_EN
            PARITY: begin
                if (sample_tick) begin
                    if (tick_last) begin
                        tick_cnt_n = 4'd0;
                        state_n    = STOP;
                        tx_n       = 1'b1;
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end
`endif

            STOP: begin
                if (sample_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        tick_cnt_n = 4'd0;
                        if (char_idx == LAST_CHAR) begin
                            state_n      = IDLE;
                            char_idx_n   = 3'd0;
                            tx_n         = 1'b1;
                            busy_n       = 1'b0;
                            frame_done_n = 1'b1;
                        end else begin
                            // Next character starts straight away, no idle gap.
                            char_idx_n = char_idx + 3'd1;
                            state_n    = START;
                            tx_n       = 1'b0;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end

            default: begin
                state_n    = IDLE;
                tick_cnt_n = 4'd0;
                bit_cnt_n  = '0;
                char_idx_n = 3'd0;
                tx_n       = 1'b1;
                busy_n     = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any frame silently.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= 4'd0;
            bit_cnt    <= '0;
            char_idx   <= 3'd0;
            value_q    <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_cnt_n;
            bit_cnt    <= bit_cnt_n;
            char_idx   <= char_idx_n;
            value_q    <= value_q_n;
            tx         <= tx_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb_uart_hex_tx: frame-level bench for uart_hex_tx. A 16x oversampling
// receiver decodes tx and checks each character against a scoreboard queue
// filled when a frame is requested; frame length is checked in sample_ticks.
module tb_uart_hex_tx;

    localparam int unsigned DATA_BITS     = 8;
    localparam int unsigned STOP_BIT_TICK = 16;
    localparam int          TICK_DIV      = 3;
`ifdef UART_HEX_TX_PARITY_EN
    localparam int          PAR_BITS      = 1;
`else
    localparam int          PAR_BITS      = 0;
`endif
    localparam int FRAME_TICKS = 5 * (16 * (1 + DATA_BITS + PAR_BITS) + STOP_BIT_TICK);
    localparam int FRAME_WAIT  = FRAME_TICKS * TICK_DIV + 400;

    logic                 clk_50MHz;
    logic                 reset;
    logic                 sample_tick;
    logic                 send;
    logic [DATA_BITS-1:0] value;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    uart_hex_tx #(
        .DATA_BITS    (DATA_BITS),
        .STOP_BIT_TICK(STOP_BIT_TICK)
    ) dut (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .sample_tick(sample_tick),
        .send       (send),
        .value      (value),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [7:0]      val;
        logic [4:0][7:0] exp;   // exp[4] is the first character on the line
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         busy_ticks = 0;
    int         rx_count = 0;
    bit         tick_en  = 1'b1;
    logic [7:0] sb_q[$];

    // 50 MHz clock.
    initial begin
        clk_50MHz = 1'b0;
        forever #10 clk_50MHz = ~clk_50MHz;
    end

    // Baud strobe: one pulse every TICK_DIV cycles while enabled.
    initial begin
        int phase;
        phase = 0;
        sample_tick = 1'b0;
        forever begin
            @(posedge clk_50MHz);
            #1;
            if (tick_en) begin
                sample_tick = (phase == TICK_DIV - 1);
                phase = (phase + 1) % TICK_DIV;
            end else begin
                sample_tick = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame_done pulses and sample_ticks spent busy.
    always @(negedge clk_50MHz) begin
        if (frame_done === 1'b1) done_cnt++;
        if (sample_tick && busy === 1'b1) busy_ticks++;
    end

    // 16x receiver sampling mid-bit, checking against the scoreboard.
    always @(negedge clk_50MHz) begin
        static int         rx_state = 0;
        static int         rx_cnt   = 0;
        static int         rx_bit   = 0;
        static logic [7:0] rx_byte  = 8'h00;
        static logic       rx_par   = 1'b0;
        logic [7:0]        exp_b;
        if (reset) begin
            rx_state = 0;
        end else if (sample_tick) begin
            case (rx_state)
                0: if (tx === 1'b0) begin rx_cnt = 1; rx_state = 1; end
                1: begin
                    rx_cnt++;
                    if (rx_cnt == 8) begin
                        check("start_bit", 32'(tx), 32'd0);
                        rx_cnt = 0; rx_bit = 0; rx_state = 2;
                    end
                end
                2: begin
                    rx_cnt++;
                    if (rx_cnt == 16) begin
                        rx_byte[rx_bit] = tx;
                        rx_cnt = 0;
                        rx_bit++;
                        if (rx_bit == DATA_BITS) rx_state = (PAR_BITS != 0) ? 3 : 4;
                    end
                end
                3: begin
                    rx_cnt++;
                    if (rx_cnt == 16) begin rx_par = tx; rx_cnt = 0; rx_state = 4; end
                end
                default: begin
                    rx_cnt++;
                    if (rx_cnt == 16) begin
                        check("stop_bit", 32'(tx), 32'd1);
                        rx_count++;
                        if (sb_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_char: got 0x%0h, expected no character", rx_byte);
                        end else begin
                            exp_b = sb_q.pop_front();
                            check("rx_char", 32'(rx_byte), 32'(exp_b));
                            if (PAR_BITS != 0) check("parity_bit", 32'(rx_par), 32'(^exp_b));
                        end
                        rx_state = 0;
                    end
                end
            endcase
        end
    end

    task automatic cyc();
        @(negedge clk_50MHz);
        #1;
    endtask

    task automatic push_exp(input logic [4:0][7:0] exp);
        for (int k = 4; k >= 0; k--) sb_q.push_back(exp[k]);
    endtask

    task automatic wait_done(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME_WAIT; i++) begin
            cyc();
            if (frame_done === 1'b1) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
        if (!ok) sb_q.delete();
    endtask

    // One complete frame with a one-cycle send pulse.
    task automatic run_frame(input logic [7:0] val, input logic [4:0][7:0] exp);
        int d0;
        bit ok;
        push_exp(exp);
        d0 = done_cnt;
        busy_ticks = 0;
        value = DATA_BITS'(val);
        send  = 1'b1;
        cyc();
        send  = 1'b0;
        value = DATA_BITS'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("tx_start_after_accept", 32'(tx), 32'd0);
        wait_done("frame_done_seen", ok);
        check("busy_low_with_done", 32'(busy), 32'd0);
        check("frame_ticks", 32'(busy_ticks), 32'(FRAME_TICKS));
        cyc();
        check("frame_done_one_cycle", 32'(frame_done), 32'd0);
        check("chars_drained", 32'(sb_q.size()), 32'd0);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        vec_t  tbl[8];
        bit    ok;
        int    d0, r0, flips, rises, hold_ticks;
        logic  tx_hold;

        tbl[0] = '{8'h3A, {8'h24, 8'h33, 8'h41, 8'h0D, 8'h0A}};
        tbl[1] = '{8'h00, {8'h24, 8'h30, 8'h30, 8'h0D, 8'h0A}};
        tbl[2] = '{8'hFF, {8'h24, 8'h46, 8'h46, 8'h0D, 8'h0A}};
        tbl[3] = '{8'h12, {8'h24, 8'h31, 8'h32, 8'h0D, 8'h0A}};
        tbl[4] = '{8'hA5, {8'h24, 8'h41, 8'h35, 8'h0D, 8'h0A}};
        tbl[5] = '{8'h9B, {8'h24, 8'h39, 8'h42, 8'h0D, 8'h0A}};
        tbl[6] = '{8'hC7, {8'h24, 8'h43, 8'h37, 8'h0D, 8'h0A}};
        tbl[7] = '{8'h60, {8'h24, 8'h36, 8'h30, 8'h0D, 8'h0A}};

        reset = 1'b1;
        send  = 1'b0;
        value = '0;
        repeat (3) cyc();
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        repeat (3) cyc();

        // Table of single frames.
        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].val, tbl[i].exp);
            repeat (5) cyc();
        end

        // Back-to-back: send held high; ignored on the frame_done cycle,
        // accepted on the next one.
        push_exp(tbl[1].exp);
        push_exp(tbl[2].exp);
        busy_ticks = 0;
        value = 8'h00;
        send  = 1'b1;
        cyc();
        value = 8'hFF;
        wait_done("b2b_first_done", ok);
        check("b2b_first_ticks", 32'(busy_ticks), 32'(FRAME_TICKS));
        check("b2b_busy_on_done", 32'(busy), 32'd0);
        cyc();
        check("b2b_gap_tx", 32'(tx), 32'd1);
        check("b2b_gap_busy", 32'(busy), 32'd0);
        busy_ticks = 0;
        cyc();
        send = 1'b0;
        check("b2b_second_busy", 32'(busy), 32'd1);
        check("b2b_second_tx", 32'(tx), 32'd0);
        wait_done("b2b_second_done", ok);
        check("b2b_second_ticks", 32'(busy_ticks), 32'(FRAME_TICKS));
        cyc();
        check("b2b_drained", 32'(sb_q.size()), 32'd0);
        repeat (5) cyc();

        // Send while busy is ignored.
        push_exp(tbl[3].exp);
        d0 = done_cnt;
        value = 8'h12;
        send  = 1'b1;
        cyc();
        send = 1'b0;
        repeat (500) cyc();
        value = 8'h55;
        send  = 1'b1;
        cyc();
        send = 1'b0;
        wait_done("busy_send_done", ok);
        r0 = rx_count;
        rises = 0;
        for (int i = 0; i < 1500; i++) begin
            cyc();
            if (busy !== 1'b0 || tx !== 1'b1) rises++;
        end
        check("busy_send_no_second_frame", 32'(rises), 32'd0);
        check("busy_send_no_extra_chars", 32'(rx_count - r0), 32'd0);
        check("busy_send_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_send_drained", 32'(sb_q.size()), 32'd0);

        // Reset in the DATA state of character index 2.
        push_exp({8'h24, 8'h33, 8'h00, 8'h00, 8'h00});
        void'(sb_q.pop_back());
        void'(sb_q.pop_back());
        void'(sb_q.pop_back());
        d0 = done_cnt;
        busy_ticks = 0;
        value = 8'h3C;
        send  = 1'b1;
        cyc();
        send = 1'b0;
        for (int i = 0; i < FRAME_WAIT && busy_ticks < 400; i++) cyc();
        check("reset_point_reached", 32'(busy_ticks >= 400), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_tx", 32'(tx), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        repeat (4) cyc();
        reset = 1'b0;
        repeat (3) cyc();
        check("reset_no_done", 32'(done_cnt - d0), 32'd0);
        check("reset_chars_before_abort", 32'(sb_q.size()), 32'd0);
        check("reset_idle_tx", 32'(tx), 32'd1);
        sb_q.delete();
        run_frame(8'hA5, tbl[4].exp);
        repeat (5) cyc();

        // sample_tick withheld for 1000 cycles mid-bit.
        push_exp(tbl[0].exp);
        busy_ticks = 0;
        value = 8'h3A;
        send  = 1'b1;
        cyc();
        send = 1'b0;
        for (int i = 0; i < FRAME_WAIT && busy_ticks < 205; i++) cyc();
        tick_en = 1'b0;
        cyc();
        cyc();
        tx_hold    = tx;
        hold_ticks = busy_ticks;
        flips = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (tx !== tx_hold || busy !== 1'b1 || frame_done !== 1'b0) flips++;
        end
        check("freeze_outputs_stable", 32'(flips), 32'd0);
        check("freeze_no_ticks", 32'(busy_ticks), 32'(hold_ticks));
        tick_en = 1'b1;
        wait_done("freeze_done", ok);
        check("freeze_frame_ticks", 32'(busy_ticks), 32'(FRAME_TICKS));
        cyc();
        check("freeze_drained", 32'(sb_q.size()), 32'd0);

        repeat (10) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the run overruns.
    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation exceeded 150000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
